core_mem_arb2: RTL

- Two-requester arbiter placed in front of a single core-side memory port: the req/gnt/rvalid protocol port of the core-to-AXI bridge.
- Lets the instruction fetch side (m0) and the data side (m1) share one AXI master.
- Round-robin grants when both requesters are active.
- Tracks the owner of every outstanding transaction in an ID FIFO and routes each rvalid back to that owner.

---
 rtl/core_mem_arb2.sv | 125 ++++++++++++
 1 files changed

// File: rtl/core_mem_arb2.sv
// rtl/core_mem_arb2.sv - two-requester round-robin arbiter for a req/gnt/rvalid memory port
// Responses are routed back through an owner FIFO that records who won each handshake.
module core_mem_arb2 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          rr_q, rr_d;
  logic          lock_q, lock_d;
  logic          lsel_q, lsel_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          owner_q [MAX_OUTSTANDING];

  logic sel, sel_req, fifo_full, hs, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    sel = rr_q;
    if (lock_q)                sel = lsel_q;
    else if (m0_req_i ^ m1_req_i) sel = m1_req_i;
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign fifo_full = (cnt_q == CW'(MAX_OUTSTANDING));
  assign s_req_o   = sel_req & ~fifo_full;
  assign hs        = s_req_o & s_gnt_i;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  assign m0_gnt_o  = hs & ~sel;
  assign m1_gnt_o  = hs & sel;

  assign pop         = s_rvalid_i & (cnt_q != '0);
  assign head        = owner_q[rd_ptr_q];
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_q;

  always_comb begin
    rr_d     = rr_q;
    lock_d   = lock_q;
    lsel_d   = lsel_q;
    err_d    = err_q | (s_rvalid_i & (cnt_q == '0));
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A pending request stays pinned to its requester until the bridge accepts it.
    if (s_req_o && !s_gnt_i) begin
      lock_d = 1'b1;
      lsel_d = sel;
    end else if (hs) begin
      lock_d = 1'b0;
      rr_d   = ~sel;
    end
    if (hs)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (hs && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!hs && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= 1'b0;
      lock_q   <= 1'b0;
      lsel_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      rr_q     <= rr_d;
      lock_q   <= lock_d;
      lsel_q   <= lsel_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && hs) owner_q[wr_ptr_q] <= sel;
  end
endmodule
